// File: rtl/load_store_unit_if.sv
// Control-unit request/response and data-memory port bundle of the load/store unit.
// The slave modport is the unit's view; master is the control unit plus memory.
interface load_store_unit_if;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] base_address;
    logic [31:0] offset;
    logic [31:0] store_data;
    logic [31:0] data_memory_read_data;
    logic [31:0] data_memory_access_address;
    logic [31:0] data_memory_write_data;
    logic        store;
    logic [31:0] load_data;
    logic        busy;
    logic        done;
    logic        access_error;

    modport slave (
        input  start, is_store, funct3, base_address, offset, store_data,
               data_memory_read_data,
        output data_memory_access_address, data_memory_write_data, store,
               load_data, busy, done, access_error
    );

    modport master (
        output start, is_store, funct3, base_address, offset, store_data,
               data_memory_read_data,
        input  data_memory_access_address, data_memory_write_data, store,
               load_data, busy, done, access_error
    );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle load/store unit: byte/half/word loads with extension, and
// sub-word stores done as read-modify-write against a word-wide data memory.
module load_store_unit (
    input  logic              clk,
    input  logic              resetn,
    load_store_unit_if.slave  bus
);
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] READ  = 3'd1;
    localparam logic [2:0] WAIT  = 3'd2;
    localparam logic [2:0] WRITE = 3'd3;
    localparam logic [2:0] DONE  = 3'd4;

    logic [2:0]  state;
    logic [31:0] ea;
    logic [2:0]  f3_q;
    logic        st_q;
    logic        err_q;
    logic [31:0] wbuf;
    logic [31:0] load_q;

    logic [31:0] ea_next;
    logic        reject;
    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_ext;
    logic [31:0] merged;

    assign ea_next = bus.base_address + bus.offset;
    assign byte_sh = {ea[1:0], 3'b000};
    assign half_sh = {ea[1], 4'b0000};

    // Reject unsupported sizes and misaligned half/word accesses before any memory traffic.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        reject = 1'b0;
        if (bus.is_store)
            reject = bus.funct3[2] | (bus.funct3[1:0] == 2'b11);
        else
            reject = (bus.funct3 == 3'b011) | (bus.funct3[2:1] == 2'b11);
        if (bus.funct3[1:0] == 2'b01 && ea_next[0])
            reject = 1'b1;
        if (bus.funct3[1:0] == 2'b10 && ea_next[1:0] != 2'b00)
            reject = 1'b1;
    end

    always_comb begin
        byte_v   = bus.data_memory_read_data[byte_sh +: 8];
        half_v   = bus.data_memory_read_data[half_sh +: 16];
        load_ext = bus.data_memory_read_data;
        case (f3_q)
            3'b000:  load_ext = {{24{byte_v[7]}}, byte_v};
            3'b001:  load_ext = {{16{half_v[15]}}, half_v};
            3'b100:  load_ext = {24'd0, byte_v};
            3'b101:  load_ext = {16'd0, half_v};
            default: load_ext = bus.data_memory_read_data;
        endcase
    end

    // Sub-word store: splice the buffered store data into the word just read.
    always_comb begin
        merged = bus.data_memory_read_data;
        if (f3_q[1:0] == 2'b00)
            merged[byte_sh +: 8] = wbuf[7:0];
        else
            merged[half_sh +: 16] = wbuf[15:0];
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only, so every
        // register samples pre-edge values regardless of statement order.
        if (!resetn) begin
            state  <= IDLE;
            ea     <= '0;
            f3_q   <= '0;
            st_q   <= 1'b0;
            err_q  <= 1'b0;
            wbuf   <= '0;
            load_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    err_q <= 1'b0;
                    if (bus.start) begin
                        ea   <= ea_next;
                        f3_q <= bus.funct3;
                        st_q <= bus.is_store;
                        if (reject) begin
                            err_q <= 1'b1;
                            state <= DONE;
                        end else if (bus.is_store) begin
                            wbuf  <= bus.store_data;
                            state <= (bus.funct3 == 3'b010) ? WRITE : READ;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                READ:  state <= WAIT;
                WAIT: begin
                    if (st_q) begin
                        wbuf  <= merged;
                        state <= WRITE;
                    end else begin
                        load_q <= load_ext;
                        state  <= DONE;
                    end
                end
                WRITE: state <= DONE;
                DONE: begin
                    err_q <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // The write strobe is also gated by reset so no pulse escapes before the reset edge.
    assign bus.store                      = resetn & (state == WRITE);
    assign bus.data_memory_access_address = {2'b00, ea[31:2]};
    assign bus.data_memory_write_data     = wbuf;
    assign bus.load_data                  = load_q;
    assign bus.busy                       = (state != IDLE);
    assign bus.done                       = (state == DONE);
    assign bus.access_error               = (state == DONE) & err_q;
endmodule
